// File: rtl/shift_arb_if.sv
// Request/response bundle for shift_arb: NREQ requester lanes plus one shared result port.
interface shift_arb_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [2*NREQ-1:0]  req_op;
   logic [32*NREQ-1:0] req_a;
   logic [5*NREQ-1:0]  req_shamt;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [31:0]        rsp_y;
   logic [1:0]         rsp_id;
   logic               rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_shamt, rsp_ready,
      input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_shamt, rsp_ready,
      output req_ready, rsp_valid, rsp_y, rsp_id, rsp_err
   );
endinterface

// File: rtl/shift_arb.sv
// Shared 32-bit shifter arbitrated among NREQ requesters, one registered result slot.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module shift_arb #(
   parameter int NREQ = 2
) (
   input logic        clk,
   input logic        rst,
   shift_arb_if.slave bus
);
   localparam int DATA_W = 32;

   function automatic logic [DATA_W-1:0] shift_fn(input logic [DATA_W-1:0] a,
                                                  input logic [4:0]        sh,
                                                  input logic [1:0]        op);
      logic signed [DATA_W-1:0] a_s;
      a_s = a;
      case (op)
         2'b00:   shift_fn = a << sh;
         2'b01:   shift_fn = a >> sh;
         2'b10:   shift_fn = $unsigned(a_s >>> sh);
         default: shift_fn = '0;
      endcase
   endfunction

   logic              win_vld;
   logic [1:0]        win;
   logic              can_accept;
   logic              xfer;
   logic [NREQ-1:0]   rdy;

   logic [DATA_W-1:0] a_p0;
   logic [4:0]        shamt_p0;
   logic [1:0]        op_p0;
   logic [DATA_W-1:0] y_p0;

   logic              vld_p1;
   logic [DATA_W-1:0] y_p1;
   logic [1:0]        id_p1;
   logic              err_p1;

`ifdef SHIFT_ARB_RR_EN
   logic [1:0] ptr;
   int         idx;

   // Search upward from ptr, wrapping at NREQ; ptr always stays below NREQ.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_vld && bus.req_valid[idx]) begin
            win_vld = 1'b1;
            win     = 2'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (xfer)
         ptr <= (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
   end
`else
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k]) begin
            win_vld = 1'b1;
            win     = 2'(k);
         end
      end
   end
`endif

   // Reset gates the grant combinationally so nothing is accepted while rst is high.
   assign can_accept = !vld_p1 || bus.rsp_ready;

   always_comb begin
      rdy = '0;
      for (int i = 0; i < NREQ; i++)
         rdy[i] = !rst && can_accept && win_vld && (win == 2'(i));
   end

   assign bus.req_ready = rdy;
   assign xfer          = |(bus.req_valid & rdy);

   // ---- p0: winner operand select and shift ----
   always_comb begin
      a_p0     = '0;
      shamt_p0 = '0;
      op_p0    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == 2'(i)) begin
            a_p0     = bus.req_a[32*i +: 32];
            shamt_p0 = bus.req_shamt[5*i +: 5];
            op_p0    = bus.req_op[2*i +: 2];
         end
      end
      y_p0 = shift_fn(a_p0, shamt_p0, op_p0);
   end

   // ---- p1: result register; replaced in place when drain and transfer coincide ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         y_p1   <= '0;
         id_p1  <= '0;
         err_p1 <= 1'b0;
      end else if (xfer) begin
         vld_p1 <= 1'b1;
         y_p1   <= y_p0;
         id_p1  <= win;
         err_p1 <= (op_p0 == 2'b11);
      end else if (bus.rsp_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.rsp_valid = vld_p1;
   assign bus.rsp_y     = y_p1;
   assign bus.rsp_id    = id_p1;
   assign bus.rsp_err   = err_p1;
endmodule

// File: tb/tb_shift_arb.sv
// Directed self-checking bench for shift_arb (NREQ=2); expectations follow SHIFT_ARB_RR_EN if defined.
module tb_shift_arb;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   shift_arb_if #(.NREQ(2)) bus ();

   shift_arb #(.NREQ(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [1:0] op,
                          input logic [31:0] a, input logic [4:0] sh);
      bus.req_valid[p]        = v;
      bus.req_op[2*p +: 2]    = op;
      bus.req_a[32*p +: 32]   = a;
      bus.req_shamt[5*p +: 5] = sh;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_shamt = '0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      set_req(0, 1'b1, 2'b00, 32'h1, 5'd1);
      #1;
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 32'h0 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got valid=%b y=%h id=%0d err=%b, want 0/0/0/0",
                  bus.rsp_valid, bus.rsp_y, bus.rsp_id, bus.rsp_err);
      end
      tests++;
      if (bus.req_ready !== 2'b00) begin
         fails++;
         $display("FAIL reset_ready: got %b, want 00", bus.req_ready);
      end
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd31);
      bus.rsp_ready = 1'b1;
      #1;
      tests++;
      if (bus.req_ready !== 2'b01) begin
         fails++;
         $display("FAIL single_ready: got %b, want 01", bus.req_ready);
      end
      step();
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 32'h8000_0000 || bus.rsp_id !== 2'd0 || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL single_rsp: got valid=%b y=%h id=%0d err=%b, want 1/80000000/0/0",
                  bus.rsp_valid, bus.rsp_y, bus.rsp_id, bus.rsp_err);
      end
      step();
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_drain: got valid=%b, want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_sra_srl();
      set_req(1, 1'b1, 2'b10, 32'h8000_0000, 5'd4);
      step();
      tests++;
      if (bus.rsp_y !== 32'hF800_0000 || bus.rsp_id !== 2'd1 || bus.rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL sra_sign: got y=%h id=%0d valid=%b, want F8000000/1/1",
                  bus.rsp_y, bus.rsp_id, bus.rsp_valid);
      end
      set_req(1, 1'b1, 2'b01, 32'h8000_0000, 5'd4);
      step();
      tests++;
      if (bus.rsp_y !== 32'h0800_0000 || bus.rsp_id !== 2'd1 || bus.rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL srl_zero: got y=%h id=%0d valid=%b, want 08000000/1/1",
                  bus.rsp_y, bus.rsp_id, bus.rsp_valid);
      end
      set_req(1, 1'b1, 2'b10, 32'h1234_5678, 5'd0);
      step();
      set_req(1, 1'b0, 2'b00, 32'h0, 5'd0);
      tests++;
      if (bus.rsp_y !== 32'h1234_5678) begin
         fails++;
         $display("FAIL shamt_zero: got y=%h, want 12345678", bus.rsp_y);
      end
      step();
   endtask

   task automatic test_contention();
      logic [1:0]  gnt [4];
      logic [31:0] yexp;
`ifdef SHIFT_ARB_RR_EN
      gnt = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
      gnt = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
      set_req(0, 1'b1, 2'b00, 32'h0000_00F0, 5'd4);
      set_req(1, 1'b1, 2'b01, 32'hF000_0000, 5'd8);
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         tests++;
         if (bus.req_ready !== ((gnt[c] == 2'd0) ? 2'b01 : 2'b10)) begin
            fails++;
            $display("FAIL contention_ready[%0d]: got %b, want grant %0d", c, bus.req_ready, gnt[c]);
         end
         step();
         yexp = (gnt[c] == 2'd0) ? 32'h0000_0F00 : 32'h00F0_0000;
         tests++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== gnt[c] || bus.rsp_y !== yexp) begin
            fails++;
            $display("FAIL contention_rsp[%0d]: got valid=%b id=%0d y=%h, want 1/%0d/%h",
                     c, bus.rsp_valid, bus.rsp_id, bus.rsp_y, gnt[c], yexp);
         end
      end
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      set_req(1, 1'b0, 2'b00, 32'h0, 5'd0);
      step();
   endtask

   task automatic test_reserved();
      set_req(0, 1'b1, 2'b11, 32'hFFFF_FFFF, 5'd3);
      step();
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      tests++;
      if (bus.rsp_y !== 32'h0 || bus.rsp_err !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL reserved_op: got y=%h err=%b id=%0d valid=%b, want 0/1/0/1",
                  bus.rsp_y, bus.rsp_err, bus.rsp_id, bus.rsp_valid);
      end
      step();
   endtask

   task automatic test_back_to_back();
      set_req(0, 1'b1, 2'b00, 32'h0000_0003, 5'd1);
      bus.rsp_ready = 1'b1;
      step();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 32'h6 || bus.rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL bp_first: got valid=%b y=%h err=%b, want 1/00000006/0",
                  bus.rsp_valid, bus.rsp_y, bus.rsp_err);
      end
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b1, 2'b00, 32'h0000_0005, 5'd2);
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.req_ready !== 2'b00) begin
            fails++;
            $display("FAIL bp_ready[%0d]: got %b, want 00", c, bus.req_ready);
         end
         step();
         tests++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 32'h6 || bus.rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL bp_hold[%0d]: got valid=%b y=%h id=%0d, want 1/00000006/0",
                     c, bus.rsp_valid, bus.rsp_y, bus.rsp_id);
         end
      end
      bus.rsp_ready = 1'b1;
      #1;
      tests++;
      if (bus.req_ready !== 2'b01) begin
         fails++;
         $display("FAIL bp_release_ready: got %b, want 01", bus.req_ready);
      end
      step();
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 32'h14) begin
         fails++;
         $display("FAIL bp_no_bubble: got valid=%b y=%h, want 1/00000014", bus.rsp_valid, bus.rsp_y);
      end
      step();
      tests++;
      if (bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_drain: got valid=%b, want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      set_req(0, 1'b1, 2'b00, 32'h0000_0001, 5'd1);
      bus.rsp_ready = 1'b1;
      step();
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      bus.rsp_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_y !== 32'h0) begin
         fails++;
         $display("FAIL async_reset: got valid=%b y=%h, want 0/00000000", bus.rsp_valid, bus.rsp_y);
      end
      step();
      rst = 1'b0;
      set_req(0, 1'b1, 2'b00, 32'h0000_000F, 5'd4);
      set_req(1, 1'b1, 2'b01, 32'h0000_00F0, 5'd4);
      bus.rsp_ready = 1'b1;
      #1;
      tests++;
      if (bus.req_ready !== 2'b01) begin
         fails++;
         $display("FAIL post_reset_grant: got %b, want 01", bus.req_ready);
      end
      step();
      set_req(0, 1'b0, 2'b00, 32'h0, 5'd0);
      set_req(1, 1'b0, 2'b00, 32'h0, 5'd0);
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_y !== 32'hF0) begin
         fails++;
         $display("FAIL post_reset_rsp: got valid=%b id=%0d y=%h, want 1/0/000000F0",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_y);
      end
      step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_sra_srl();
      test_contention();
      test_reserved();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
